// File: rtl/pe_leaf_tx_if.sv
// Leaf transmitter bus: PE-side valid/ready word stream plus the network-side
// packet, resend and retry-count signals.
interface pe_leaf_tx_if #(
  parameter int num_leaves = 256,
  parameter int payload_sz = 23
);
  localparam int LW   = $clog2(num_leaves);
  localparam int DW   = payload_sz - LW;
  localparam int P_SZ = 1 + LW + payload_sz;

  logic            s_valid;
  logic            s_ready;
  logic [LW-1:0]   s_dest;
  logic [DW-1:0]   s_data;
  logic [P_SZ-1:0] pe_interface;
  logic            resend;
  logic [15:0]     retry_cnt;

  modport master (
    output s_valid, s_dest, s_data, resend,
    input  s_ready, pe_interface, retry_cnt
  );

  modport slave (
    input  s_valid, s_dest, s_data, resend,
    output s_ready, pe_interface, retry_cnt
  );
endinterface

// File: rtl/pe_leaf_tx.sv
// Leaf-side packet transmitter: FIFO-buffered PE words, formatted into packets
// and held on resend. Define PE_TX_SEQ_EN to stamp a wrapping sequence number.
module pe_leaf_tx #(
  parameter int num_leaves = 256,
  parameter int payload_sz = 23,
  parameter int p_sz       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  pe_leaf_tx_if.slave bus
);
  localparam int LW = $clog2(num_leaves);
  localparam int DW = payload_sz - LW;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q;
  logic [p_sz-1:0]   pkt_q;
  logic [15:0]       retry_q;
  logic [LW+DW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [LW-1:0]     seq_stamp;
  logic [LW+DW-1:0]  head;
  logic [p_sz-1:0]   next_pkt;
  logic              full, empty, push, accept, load;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.s_valid & bus.s_ready;
  assign accept   = (state_q == SEND) & ~bus.resend;
  assign load     = ((state_q == IDLE) | accept) & ~empty;
  assign head     = mem_q[rd_ptr_q];
  assign next_pkt = {1'b1, head[LW+DW-1:DW], seq_stamp, head[DW-1:0]};

  // Ready is gated by reset itself so the PE sees 0 throughout reset.
  assign bus.s_ready      = reset & ~full;
  assign bus.pe_interface = pkt_q;
  assign bus.retry_cnt    = retry_q;

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.s_dest, bus.s_data};
  end

`ifdef PE_TX_SEQ_EN
  logic [LW-1:0] seq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    seq_q <= '0;
    else if (load) seq_q <= seq_q + LW'(1);
  end

  assign seq_stamp = seq_q;
`else
  assign seq_stamp = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      retry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q <= SEND;
            pkt_q   <= next_pkt;
          end
        end
        SEND: begin
          if (bus.resend) begin
            if (retry_q != '1) retry_q <= retry_q + 16'd1;
          end else if (!empty) begin
            pkt_q <= next_pkt;
          end else begin
            state_q <= IDLE;
            pkt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          pkt_q   <= '0;
        end
      endcase
    end
  end
endmodule
